// File: rtl/cache_bank_ctrl.sv
`timescale 1ns/1ps
// Cache bank SRAM initiator: zero-fills every line out of reset, then arbitrates
// single-line writes against 4-lane reads and returns read data via valid/ready.
module cache_bank_ctrl #(
    parameter int ADR  = 6,
    parameter int DAT  = 32,
    parameter int DPTH = 64
) (
    input  logic           Clk,
    input  logic           Reset,
    output logic           busy,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [ADR-1:0] wr_addr,
    input  logic [DAT-1:0] wr_data,
    input  logic           rd_valid,
    output logic           rd_ready,
    input  logic [ADR-1:0] rd_addr_0,
    input  logic [ADR-1:0] rd_addr_1,
    input  logic [ADR-1:0] rd_addr_2,
    input  logic [ADR-1:0] rd_addr_3,
    input  logic [3:0]     rd_lane_en,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [3:0]     rsp_lane_en,
    output logic [DAT-1:0] rsp_data_0,
    output logic [DAT-1:0] rsp_data_1,
    output logic [DAT-1:0] rsp_data_2,
    output logic [DAT-1:0] rsp_data_3,
    input  logic [DAT-1:0] ram_dout_0,
    input  logic [DAT-1:0] ram_dout_1,
    input  logic [DAT-1:0] ram_dout_2,
    input  logic [DAT-1:0] ram_dout_3,
    output logic           ram_cs,
    output logic           ram_we,
    output logic           ram_rd,
    output logic [ADR-1:0] ram_wa,
    output logic [DAT-1:0] ram_din,
    output logic [ADR-1:0] ram_ra_0,
    output logic [ADR-1:0] ram_ra_1,
    output logic [ADR-1:0] ram_ra_2,
    output logic [ADR-1:0] ram_ra_3
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    typedef enum logic {G_READ, G_WRITE} grant_t;

    localparam logic [ADR-1:0] LAST_LINE = ADR'(DPTH - 1);

    state_t         state_reg;
    grant_t         last_grant_reg;
    logic [ADR-1:0] init_cnt_reg;
    logic           busy_reg;
    logic           rsp_valid_reg;
    logic [3:0]     rsp_lane_en_reg;

    logic           read_ok;
    logic           grant_wr;
    logic           grant_rd;
    logic           init_active;

    logic [ADR-1:0] rd_addr_arr [4];
    logic [ADR-1:0] ram_ra_arr  [4];

    // Strobes are gated by Reset so they fall the instant reset asserts.
    assign init_active = !Reset && (state_reg == ST_INIT);

    always_comb begin
        read_ok  = rd_valid && (!rsp_valid_reg || rsp_ready);
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (!Reset && state_reg == ST_RUN) begin
            if (wr_valid && read_ok) begin
                grant_wr = (last_grant_reg == G_READ);
                grant_rd = (last_grant_reg == G_WRITE);
            end else begin
                grant_wr = wr_valid;
                grant_rd = read_ok;
            end
        end
    end

    assign wr_ready = grant_wr;
    assign rd_ready = grant_rd;
    assign ram_cs   = init_active || grant_wr || grant_rd;
    assign ram_we   = init_active || grant_wr;
    assign ram_rd   = grant_rd;
    assign ram_wa   = grant_wr ? wr_addr : (init_active ? init_cnt_reg : '0);
    assign ram_din  = grant_wr ? wr_data : '0;

    assign rd_addr_arr[0] = rd_addr_0;
    assign rd_addr_arr[1] = rd_addr_1;
    assign rd_addr_arr[2] = rd_addr_2;
    assign rd_addr_arr[3] = rd_addr_3;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign ram_ra_arr[gi] = grant_rd ? rd_addr_arr[gi] : '0;
        end
    endgenerate

    assign ram_ra_0 = ram_ra_arr[0];
    assign ram_ra_1 = ram_ra_arr[1];
    assign ram_ra_2 = ram_ra_arr[2];
    assign ram_ra_3 = ram_ra_arr[3];

    // The SRAM holds its outputs until the next read, and no read issues while a
    // response is unconsumed, so the data path needs no capture register.
    assign rsp_data_0 = ram_dout_0;
    assign rsp_data_1 = ram_dout_1;
    assign rsp_data_2 = ram_dout_2;
    assign rsp_data_3 = ram_dout_3;

    assign busy        = busy_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_lane_en = rsp_lane_en_reg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg       <= ST_INIT;
            init_cnt_reg    <= '0;
            busy_reg        <= 1'b1;
            rsp_valid_reg   <= 1'b0;
            rsp_lane_en_reg <= 4'b0;
            last_grant_reg  <= G_READ;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    init_cnt_reg <= init_cnt_reg + 1'b1;
                    if (init_cnt_reg == LAST_LINE) begin
                        state_reg <= ST_RUN;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    if (grant_rd) begin
                        rsp_valid_reg   <= 1'b1;
                        rsp_lane_en_reg <= rd_lane_en;
                        last_grant_reg  <= G_READ;
                    end else if (rsp_valid_reg && rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                    end
                    if (grant_wr) begin
                        last_grant_reg <= G_WRITE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_bank_ctrl.sv
`timescale 1ns/1ps
// Bench for cache_bank_ctrl: behavioural 1-write/4-read SRAM, directed vector
// table for the RUN-state handshake plus sequences for fill, arbitration and stalls.
module tb_cache_bank_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        busy;
    logic        wr_valid, wr_ready;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [5:0]  rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3;
    logic [3:0]  rd_lane_en;
    logic        rsp_valid, rsp_ready;
    logic [3:0]  rsp_lane_en;
    logic [31:0] rsp_data_0, rsp_data_1, rsp_data_2, rsp_data_3;
    logic [31:0] ram_dout_0, ram_dout_1, ram_dout_2, ram_dout_3;
    logic        ram_cs, ram_we, ram_rd;
    logic [5:0]  ram_wa;
    logic [31:0] ram_din;
    logic [5:0]  ram_ra_0, ram_ra_1, ram_ra_2, ram_ra_3;

    int errors = 0;
    int checks = 0;
    int overlap = 0;
    logic garbage_en;

    always #5 Clk = ~Clk;

    cache_bank_ctrl #(.ADR(6), .DAT(32), .DPTH(64)) dut (
        .Clk(Clk), .Reset(Reset), .busy(busy),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .rd_addr_3(rd_addr_3),
        .rd_lane_en(rd_lane_en),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lane_en(rsp_lane_en),
        .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1), .rsp_data_2(rsp_data_2), .rsp_data_3(rsp_data_3),
        .ram_dout_0(ram_dout_0), .ram_dout_1(ram_dout_1), .ram_dout_2(ram_dout_2), .ram_dout_3(ram_dout_3),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_rd(ram_rd), .ram_wa(ram_wa), .ram_din(ram_din),
        .ram_ra_0(ram_ra_0), .ram_ra_1(ram_ra_1), .ram_ra_2(ram_ra_2), .ram_ra_3(ram_ra_3)
    );

    // SRAM model; garbage preload makes the zero-fill observable.
    logic [31:0] mem [64];
    always @(posedge Clk) begin
        if (garbage_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A50000 | 32'(i);
        end else begin
            if (ram_cs && ram_we) mem[ram_wa] <= ram_din;
            if (ram_cs && ram_rd) begin
                ram_dout_0 <= mem[ram_ra_0];
                ram_dout_1 <= mem[ram_ra_1];
                ram_dout_2 <= mem[ram_ra_2];
                ram_dout_3 <= mem[ram_ra_3];
            end
        end
    end

    always @(negedge Clk) if (ram_we && ram_rd) overlap++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        wr_valid = 0; wr_addr = 0; wr_data = 0;
        rd_valid = 0; rd_addr_0 = 0; rd_addr_1 = 0; rd_addr_2 = 0; rd_addr_3 = 0;
        rd_lane_en = 0; rsp_ready = 1;
    endtask

    task automatic set_rd(input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2,
                          input logic [5:0] a3, input logic [3:0] le);
        rd_valid = 1; rd_addr_0 = a0; rd_addr_1 = a1; rd_addr_2 = a2; rd_addr_3 = a3;
        rd_lane_en = le;
    endtask

    // Called right after Reset releases (posedge+1); leaves time at posedge+1 in RUN.
    task automatic check_fill();
        for (int i = 0; i < 64; i++) begin
            @(negedge Clk);
            check("fill_busy", busy, 1);
            check("fill_wa", ram_wa, i);
            check("fill_we_cs", {ram_cs, ram_we, ram_rd}, 3'b110);
            check("fill_din", ram_din, 0);
            check("fill_ready", {wr_ready, rd_ready}, 2'b00);
        end
        @(negedge Clk);
        check("post_fill_busy", busy, 0);
        check("post_fill_cs", ram_cs, 0);
        @(posedge Clk); #1;
        $display("fill sequence done: checks=%0d errors=%0d", checks, errors);
    endtask

    typedef struct {
        logic wv; logic [5:0] wa; logic [31:0] wd;
        logic rv; logic [5:0] ra0, ra1, ra2, ra3; logic [3:0] le; logic rr;
        logic ewr, erd, ev; logic [3:0] ele; logic [31:0] ed0, ed1, ed2, ed3;
    } vec_t;

    vec_t vt [9];

    initial begin
        vt[0] = '{1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 4'b0000, 1'b1,
                  1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0};
        vt[1] = '{1'b0, 6'd0, 32'h0, 1'b1, 6'd5, 6'd0, 6'd63, 6'd5, 4'b1011, 1'b1,
                  1'b0, 1'b1, 1'b1, 4'b1011, 32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF};
        vt[2] = '{1'b1, 6'd7, 32'h1, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 4'b0000, 1'b1,
                  1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0};
        vt[3] = '{1'b0, 6'd0, 32'h0, 1'b1, 6'd7, 6'd7, 6'd5, 6'd1, 4'b0000, 1'b0,
                  1'b0, 1'b1, 1'b1, 4'b0000, 32'h1, 32'h1, 32'hDEADBEEF, 32'h0};
        vt[4] = '{1'b1, 6'd1, 32'h11111111, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 4'b0000, 1'b0,
                  1'b1, 1'b0, 1'b1, 4'b0000, 32'h1, 32'h1, 32'hDEADBEEF, 32'h0};
        vt[5] = '{1'b1, 6'd2, 32'h22, 1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 4'b1111, 1'b1,
                  1'b0, 1'b1, 1'b1, 4'b1111, 32'h11111111, 32'h0, 32'h0, 32'h0};
        vt[6] = '{1'b1, 6'd2, 32'h22, 1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 4'b1111, 1'b1,
                  1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0};
        vt[7] = '{1'b1, 6'd9, 32'h99, 1'b1, 6'd2, 6'd2, 6'd2, 6'd2, 4'b0100, 1'b1,
                  1'b0, 1'b1, 1'b1, 4'b0100, 32'h22, 32'h22, 32'h22, 32'h22};
        vt[8] = '{1'b0, 6'd0, 32'h0, 1'b1, 6'd9, 6'd9, 6'd9, 6'd9, 4'b1111, 1'b0,
                  1'b0, 1'b0, 1'b1, 4'b0100, 32'h22, 32'h22, 32'h22, 32'h22};

        // Reset state
        set_idle();
        Reset = 1; garbage_en = 1;
        @(negedge Clk);
        check("rst_strobes", {ram_cs, ram_we, ram_rd}, 3'b000);
        check("rst_busy", busy, 1);
        check("rst_rsp", {rsp_valid, rsp_lane_en}, 5'b0);
        check("rst_ready", {wr_ready, rd_ready}, 2'b00);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        garbage_en = 0; Reset = 0;
        check_fill();

        // Directed vector table
        for (int v = 0; v < 9; v++) begin
            wr_valid = vt[v].wv; wr_addr = vt[v].wa; wr_data = vt[v].wd;
            rd_valid = vt[v].rv; rd_addr_0 = vt[v].ra0; rd_addr_1 = vt[v].ra1;
            rd_addr_2 = vt[v].ra2; rd_addr_3 = vt[v].ra3; rd_lane_en = vt[v].le;
            rsp_ready = vt[v].rr;
            @(negedge Clk);
            check($sformatf("v%0d_ready", v), {wr_ready, rd_ready}, {vt[v].ewr, vt[v].erd});
            check($sformatf("v%0d_strobes", v), {ram_cs, ram_we, ram_rd},
                  {vt[v].ewr | vt[v].erd, vt[v].ewr, vt[v].erd});
            if (vt[v].ewr) check($sformatf("v%0d_wa_din", v), {ram_wa, ram_din}, {vt[v].wa, vt[v].wd});
            if (vt[v].erd) check($sformatf("v%0d_ra", v), {ram_ra_0, ram_ra_1, ram_ra_2, ram_ra_3},
                                 {vt[v].ra0, vt[v].ra1, vt[v].ra2, vt[v].ra3});
            @(posedge Clk); #1;
            check($sformatf("v%0d_rsp_valid", v), rsp_valid, vt[v].ev);
            if (vt[v].ev) begin
                check($sformatf("v%0d_lane_en", v), rsp_lane_en, vt[v].ele);
                check($sformatf("v%0d_data01", v), {rsp_data_0, rsp_data_1}, {vt[v].ed0, vt[v].ed1});
                check($sformatf("v%0d_data23", v), {rsp_data_2, rsp_data_3}, {vt[v].ed2, vt[v].ed3});
            end
            $display("vector %0d: wr_ready=%0b rd_ready=%0b rsp_valid=%0b lane=%b d0=%h",
                     v, vt[v].ewr, vt[v].erd, rsp_valid, rsp_lane_en, rsp_data_0);
        end

        // Both requesters active for 6 cycles: last grant was a read, so W,R,W,R,W,R
        set_idle();
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1; wr_addr = 6'd40; wr_data = 32'(i);
            set_rd(6'd40, 6'd40, 6'd40, 6'd40, 4'b1111);
            rsp_ready = 1;
            @(negedge Clk);
            check($sformatf("alt%0d_wr_ready", i), wr_ready, (i % 2 == 0));
            check($sformatf("alt%0d_rd_ready", i), rd_ready, (i % 2 == 1));
            @(posedge Clk); #1;
            $display("alternation cycle %0d: wr_ready=%0b rd_ready=%0b", i, (i % 2 == 0), (i % 2 == 1));
        end
        check("alt_last_data", rsp_data_0, 32'd4);
        check("alt_last_valid", rsp_valid, 1);

        // Stall: response held for 3 cycles while another read waits
        set_idle();
        set_rd(6'd5, 6'd5, 6'd5, 6'd5, 4'b0001);
        @(negedge Clk);
        check("stall_first_rd_ready", rd_ready, 1);
        @(posedge Clk); #1;
        set_rd(6'd7, 6'd7, 6'd7, 6'd7, 4'b1000);
        rsp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check($sformatf("stall%0d_rd_ready", i), rd_ready, 0);
            check($sformatf("stall%0d_rsp", i), {rsp_valid, rsp_lane_en, rsp_data_0}, {1'b1, 4'b0001, 32'hDEADBEEF});
            @(posedge Clk); #1;
            $display("stall cycle %0d: rsp_valid=%0b d0=%h", i, rsp_valid, rsp_data_0);
        end
        rsp_ready = 1;
        @(negedge Clk);
        check("unstall_rd_ready", rd_ready, 1);
        @(posedge Clk); #1;
        check("unstall_rsp", {rsp_valid, rsp_lane_en, rsp_data_0}, {1'b1, 4'b1000, 32'h1});
        set_idle();
        @(posedge Clk); #1;
        check("drain_rsp_valid", rsp_valid, 0);

        // Reset mid-fill at init_cnt = 20
        Reset = 1;
        @(posedge Clk); #1;
        Reset = 0;
        repeat (20) @(posedge Clk);
        #1;
        check("midfill_wa", ram_wa, 20);
        Reset = 1;
        #1;
        check("midfill_rst_strobes", {ram_cs, ram_we, ram_rd}, 3'b000);
        check("midfill_rst_busy", busy, 1);
        @(posedge Clk); #1;
        Reset = 0;
        check_fill();

        // Fill after mid-fill reset cleared earlier writes
        set_rd(6'd5, 6'd7, 6'd40, 6'd2, 4'b1111);
        @(negedge Clk);
        check("refill_rd_ready", rd_ready, 1);
        @(posedge Clk); #1;
        check("refill_data", {rsp_data_0, rsp_data_1, rsp_data_2, rsp_data_3}, 128'h0);
        set_idle();
        @(posedge Clk); #1;

        check("we_rd_exclusive", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
